// File: rtl/mpc_sram_req_adapter.sv
// mpc_sram_req_adapter
//   Request/response front end for a single-port 1RW SRAM macro wrapper.
//   Accepted requests drive the SRAM strobes combinationally in the same
//   cycle. Read data returns one cycle later and is captured into a small
//   response FIFO that feeds a valid/ready response channel. The request
//   side is credit-gated on registered state only, so response
//   backpressure never loses data and never reaches req_ready
//   combinationally.
//
//   Optional feature macro: MPC_SRAM_ADAPTER_WRESP_EN
//     defined     : accepted writes also take a credit and return an ack
//                   entry (rsp_is_wr = 1, rsp_rdata = 0), in order with reads.
//     not defined : writes return nothing; rsp_is_wr is tied to 0.
//
// Parameters
//   ADDR_SIZE  SRAM address width (instantiator must set >= 1)
//   DATA_SIZE  data width (instantiator must set >= 1)
//   RSP_DEPTH  response FIFO entries (>= 2; >= 3 for one read per cycle)
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_wdata     request payload (1 = write)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_is_wr            response payload from FIFO head
//   sram_cs, sram_we, sram_addr,
//   sram_wdata                      SRAM strobes (driven for accepted requests)
//   sram_rdata                      SRAM read data, one cycle after a read
module mpc_sram_req_adapter #(
  parameter int ADDR_SIZE = 0,
  parameter int DATA_SIZE = 0,
  parameter int RSP_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_is_wr,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0] sram_wdata,
  input  logic [DATA_SIZE-1:0] sram_rdata
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

  logic                 acc;
  logic                 pend;
  logic                 pend_set;
  logic                 push;
  logic                 pop;
  logic [CW-1:0]        cnt;
  logic [CW:0]          used;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [DATA_SIZE-1:0] push_data;
  logic [DATA_SIZE-1:0] mem_data [RSP_DEPTH];

  // Credits in use: entries already in the FIFO plus the one access whose
  // data is on sram_rdata this cycle. Registered state only.
  assign used      = {1'b0, cnt} + {{CW{1'b0}}, pend};
  assign req_ready = rst_n && (used < DEPTH_C);
  assign acc       = req_valid && req_ready;

  assign sram_cs    = acc;
  assign sram_we    = req_we;
  assign sram_addr  = req_addr;
  assign sram_wdata = req_wdata;

  assign push      = pend;
  assign rsp_valid = rst_n && (cnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = mem_data[rd_ptr];

`ifdef MPC_SRAM_ADAPTER_WRESP_EN
  logic pend_wr;
  logic mem_wr [RSP_DEPTH];

  assign pend_set  = acc;
  assign push_data = pend_wr ? '0 : sram_rdata;
  assign rsp_is_wr = mem_wr[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_wr <= 1'b0;
    end else begin
      pend_wr <= acc && req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wr[wr_ptr] <= pend_wr;
    end
  end
`else
  assign pend_set  = acc && !req_we;
  assign push_data = sram_rdata;
  assign rsp_is_wr = 1'b0;
`endif

  // Pending access and FIFO bookkeeping. Reset wins over a coincident push,
  // which discards any read in flight at the reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend   <= 1'b0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pend <= pend_set;
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Data storage is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= push_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (cnt <= CW'(RSP_DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_mpc_sram_req_adapter.sv
// Testbench for mpc_sram_req_adapter (RSP_DEPTH = 3, 8-bit address, 16-bit
// data). Contains a behavioural SRAM, a transaction-level expectation queue
// checked every cycle, and directed tests with literal expected values.
// Honours MPC_SRAM_ADAPTER_WRESP_EN the same way the design does.
module tb_mpc_sram_req_adapter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 3;
`ifdef MPC_SRAM_ADAPTER_WRESP_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_is_wr;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  mpc_sram_req_adapter #(
    .ADDR_SIZE(AW),
    .DATA_SIZE(DW),
    .RSP_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_is_wr (rsp_is_wr),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural 1RW SRAM with one-cycle read latency.
  logic [DW-1:0] sram_mem [256];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected responses: every accepted request that owes a response, with
  // the cycle from which it may be presented.
  typedef struct {
    logic [DW-1:0] data;
    logic          is_wr;
    int unsigned   due;
  } exp_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          is_wr;
    int unsigned   at;
  } got_t;

  exp_t          q[$];
  got_t          got[$];
  logic [DW-1:0] ref_mem [256];
  int unsigned   cyc = 0;

  always @(negedge clk) begin : compare
    logic e_ready;
    logic e_valid;
    logic e_cs;
    e_ready = rst_n && (q.size() < DEPTH);
    e_valid = rst_n && (q.size() != 0) && (q[0].due <= cyc);
    e_cs    = e_ready && req_valid;
    chk("req_ready", req_ready, e_ready);
    chk("sram_cs", sram_cs, e_cs);
    chk("sram_we", sram_we, req_we);
    chk("sram_addr", sram_addr, req_addr);
    chk("sram_wdata", sram_wdata, req_wdata);
    chk("rsp_valid", rsp_valid, e_valid);
    if (e_valid) begin
      chk("rsp_rdata", rsp_rdata, q[0].data);
      chk("rsp_is_wr", rsp_is_wr, q[0].is_wr);
    end
    if (rsp_valid && rsp_ready) got.push_back('{rsp_rdata, rsp_is_wr, cyc});
    if (!rst_n) begin
      q.delete();
    end else begin
      if (e_valid && rsp_ready) void'(q.pop_front());
      if (e_cs) begin
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
          if (WR_ACK) q.push_back('{'0, 1'b1, cyc + 2});
        end else begin
          q.push_back('{ref_mem[req_addr], 1'b0, cyc + 2});
        end
      end
    end
    cyc++;
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_start();
      req_valid = 1'b0;
    end
  endtask

  // Offers one request until accepted; returns with req_valid still high
  // just after the accepting cycle's falling edge.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      cyc_start();
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      if (req_ready) done = 1'b1;
      else waits++;
    end
    chk("send_accepted", done, 1);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) @(posedge clk);
    @(posedge clk);
    chk("rsp_count", got.size(), n);
  endtask

  initial begin
    int w;
    int next;

    // Reset held with a request offered.
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sram_cs", sram_cs, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end
    cyc_start();
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // Write then read of the same address; read response two cycles later.
    got.delete();
    send(1'b1, 8'h05, 16'hA5A5, w);
    send(1'b0, 8'h05, 16'h0000, w);
    cyc_start();
    req_valid = 1'b0;
    @(negedge clk);
    chk("wr_rd_t1_valid", rsp_valid, WR_ACK);
    @(negedge clk);
    chk("wr_rd_t2_valid", rsp_valid, 1);
    chk("wr_rd_t2_data", rsp_rdata, 32'hA5A5);
    chk("wr_rd_t2_is_wr", rsp_is_wr, 0);
    idle(3);

    // Streaming: preload addr*3, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(i * 3), w);
    idle(4);
    got.delete();
    for (int i = 0; i < 16; i++) begin
      send(1'b0, AW'(i), '0, w);
      chk("stream_no_stall", w, 0);
    end
    idle(1);
    wait_got(16, 40);
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      chk("stream_data", got[i].data, i * 3);
      if (i > 0) chk("stream_consecutive", got[i].at, got[i-1].at + 1);
    end

    // Backpressure: 8 reads of addr 4..11 (data 12..33) with rsp_ready low.
    idle(2);
    got.delete();
    rsp_ready = 1'b0;
    next = 0;
    for (int c = 0; c < 60 && next < 8; c++) begin
      cyc_start();
      if (c == 12) rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(4 + next); req_wdata = '0;
      @(negedge clk);
      if (c == 6 || c == 10) begin
        chk("bp_accepted", next, DEPTH);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_head_data", rsp_rdata, 12);
        chk("bp_head_valid", rsp_valid, 1);
      end
      if (req_ready) next++;
    end
    chk("bp_all_accepted", next, 8);
    idle(1);
    wait_got(8, 40);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_order", got[i].data, 12 + 3 * i);

    // Reset in the cycle after a read is accepted.
    idle(2);
    got.delete();
    send(1'b0, 8'h03, '0, w);
    cyc_start();
    req_valid = 1'b0; rst_n = 1'b0;
    cyc_start();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk);
    chk("mid_rst_log_empty", got.size(), 0);
    send(1'b0, 8'h02, '0, w);
    idle(1);
    wait_got(1, 10);
    if (got.size() > 0) chk("mid_rst_read2", got[0].data, 6);

    // Write / read / write sequence.
    idle(2);
    got.delete();
    send(1'b1, 8'h01, 16'h1111, w);
    send(1'b0, 8'h01, '0, w);
    send(1'b1, 8'h02, 16'h2222, w);
    idle(1);
`ifdef MPC_SRAM_ADAPTER_WRESP_EN
    wait_got(3, 20);
    if (got.size() >= 3) begin
      chk("wresp0_is_wr", got[0].is_wr, 1);
      chk("wresp0_data", got[0].data, 0);
      chk("wresp1_is_wr", got[1].is_wr, 0);
      chk("wresp1_data", got[1].data, 32'h1111);
      chk("wresp2_is_wr", got[2].is_wr, 1);
      chk("wresp2_data", got[2].data, 0);
    end
`else
    wait_got(1, 20);
    repeat (4) @(posedge clk);
    chk("wrw_only_read_rsp", got.size(), 1);
    if (got.size() > 0) begin
      chk("wrw_read_data", got[0].data, 32'h1111);
      chk("wrw_read_is_wr", got[0].is_wr, 0);
    end
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpc_sram_req_adapter.md
# mpc_sram_req_adapter

Request/response front end for the single-port 1RW SRAM macro wrapper. Converts a valid/ready request channel (read or write) into the SRAM's `cs`/`we`/`addr`/`wdata` strobes, and captures the SRAM's one-cycle-latency `rdata` into a response FIFO. The FIFO presents read data on a valid/ready response channel with full backpressure support and no lost data. Sits between any memory client (DMA, table walker, CPU port) and the SRAM instance.

## Interface
- `ADDR_SIZE`, default 0: SRAM address width; must be set ≥1 by the instantiator.
- `DATA_SIZE`, default 0: data width; must be set ≥1 by the instantiator.
- `RSP_DEPTH`, default 3: response FIFO entries. Minimum 2. A value of 3 or more is required for one read per cycle with `rsp_ready` held high.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted when `req_valid && req_ready`.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, ADDR_SIZE: request address.
- `req_wdata`, in, DATA_SIZE: write data.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata`, out, DATA_SIZE: read data; 0 for write responses.
- `rsp_is_wr`, out, 1: response is a write ack. Always 0 when the `_EN` feature is off.
- `sram_cs`, out, 1: SRAM chip select.
- `sram_we`, out, 1: SRAM write enable.
- `sram_addr`, out, ADDR_SIZE: SRAM address.
- `sram_wdata`, out, DATA_SIZE: SRAM write data.
- `sram_rdata`, in, DATA_SIZE: SRAM read data, valid one cycle after a `cs && !we` cycle.

## Operation
- Accept: `acc = req_valid && req_ready`.
- SRAM drive (combinational): `sram_cs = acc`; `sram_we = req_we`; `sram_addr = req_addr`; `sram_wdata = req_wdata`.
- Pending flag `pend`: set on the edge after an accepted read (or an accepted write, when write acks are enabled); clear otherwise. One SRAM access at most per cycle, so `pend` is a single bit.
- Capture: on the cycle where `pend` = 1, push `sram_rdata` into the response FIFO. Write-ack entries push data 0 with `is_wr` = 1.
- FIFO: circular buffer with read and write pointers that wrap at `RSP_DEPTH`, plus an occupancy counter `cnt` of width `$clog2(RSP_DEPTH+1)`. Push and pop in the same cycle leave `cnt` unchanged.
- Credit: `req_ready = rst_n && (cnt + pend) < RSP_DEPTH`. This is registered-state only; there is no combinational path from `rsp_ready` to `req_ready`.
- Without write acks, a write consumes no credit but is still gated by `req_ready`, so at most one request is accepted per cycle.
- Ordering: responses are returned strictly in request order.
- Same-address read after write returns the new data. Write after read returns the old data.
- `rsp_valid = (cnt != 0)`. `rsp_rdata` and `rsp_is_wr` come from the head entry. The head entry is held stable while `rsp_valid && !rsp_ready`.
- Overflow is impossible by construction. A verification assertion must check that `cnt` never exceeds `RSP_DEPTH`.

## Timing
- Reset (rst_n = 0 at a rising edge): `cnt`, `pend` and both pointers go to 0. Any in-flight SRAM read is discarded. FIFO data contents are not reset.
- Output values while in reset: `rsp_valid` = 0, `req_ready` = 0, `sram_cs` = 0.
- Read latency: request accepted in cycle t → SRAM access in t → `sram_rdata` valid in t+1 → `rsp_valid` = 1 in t+2.
- Throughput: with `RSP_DEPTH` ≥ 3 and `rsp_ready` = 1, one read is accepted per cycle indefinitely. With `RSP_DEPTH` = 2, at most 2 reads per 3 cycles.
- Backpressure: with `rsp_ready` = 0, exactly `RSP_DEPTH` reads are accepted, then `req_ready` = 0. `req_ready` returns to 1 the cycle after the first pop.
- Reset mid-stream: a response pending at the reset edge is never presented.

## Configuration
- `MPC_SRAM_ADAPTER_WRESP_EN` defined: every accepted write also takes a credit, sets `pend`, and pushes an ack entry (`rsp_is_wr` = 1, `rsp_rdata` = 0) two cycles after acceptance, in order with reads.
- Not defined: writes produce no response; `rsp_is_wr` is tied 0; write-ack logic is absent.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with `req_valid` = 1 → `sram_cs`, `req_ready` and `rsp_valid` stay 0. First cycle after release: `req_ready` = 1.
- Write then read: write addr 0x5 data 0xA5A5, then read addr 0x5 on the next cycle → `rsp_rdata` = 0xA5A5 with `rsp_valid` rising exactly 2 cycles after the read is accepted. Repeat with `RSP_DEPTH` = 3.
- Streaming: 16 back-to-back reads of addr 0..15 preloaded with value = addr×3, `rsp_ready` = 1 → `req_ready` never drops; responses 0, 3, …, 45 arrive in order on consecutive cycles.
- Backpressure: `rsp_ready` = 0 and 8 reads offered → exactly `RSP_DEPTH` accepted, `req_ready` = 0, head data stable. Raise `rsp_ready` → all 8 reads complete in order; FIFO pointers wrap with no loss or duplication.
- Reset mid-operation: assert `rst_n` = 0 in the cycle after a read is accepted → no response is ever presented; a subsequent read of addr 0x2 returns the correct data.
- With `MPC_SRAM_ADAPTER_WRESP_EN`: write addr 0x1, read addr 0x1, write addr 0x2 → three responses in order, flagged wr/rd/wr. The read data equals the first write's data; both ack entries carry `rsp_rdata` = 0.
